// File: rtl/mem_map_pkg.sv
// Shared memory map, UART status layout and FSM state type for the CPU
// data-memory responder.
//   RAM_BASE        : byte address of data RAM word 0 (default placement)
//   UART_DATA_ADDR  : RX data read / TX FIFO push
//   UART_STAT_ADDR  : status read, write clears rx_overrun
//   CYCLE_ADDR      : free-running cycle counter (read-only)
package mem_map_pkg;

  localparam logic [31:0] RAM_BASE       = 32'h1001_0000;
  localparam logic [31:0] UART_DATA_ADDR = 32'h4000_0010;
  localparam logic [31:0] UART_STAT_ADDR = 32'h4000_0014;
  localparam logic [31:0] CYCLE_ADDR     = 32'h4000_0018;

  localparam int unsigned STAT_TXNF   = 0;
  localparam int unsigned STAT_RXV    = 1;
  localparam int unsigned STAT_OVR    = 2;
  localparam int unsigned STAT_TXIDLE = 3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Word-granular address match; byte-offset bits are ignored.
  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/uart_rx_deser.sv
// UART receive path: 2-flop input synchronizer, start/data/stop FSM and
// the single-byte holding register.
//   clk, reset   : clock, asynchronous active-high reset
//   i_rxd        : raw serial input (asynchronous to clk)
//   i_pop        : CPU read of UART_DATA this cycle (ignored when empty)
//   i_clr_ovr    : clear the sticky overrun flag
//   o_data       : held byte
//   o_valid      : held byte not yet consumed
//   o_overrun    : a byte was lost because the holding register was full
module uart_rx_deser
  import mem_map_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rxd,
  input  logic       i_pop,
  input  logic       i_clr_ovr,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_overrun
);

  localparam int unsigned CW = $clog2(BAUD_DIV);

  uart_state_t   r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ovr;

  logic w_deliver;
  logic w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_prev && !r_sync2) begin
            r_cnt   <= '0;
            r_state <= START;
          end
        end
        START: begin
          // Half a bit in: confirm the start bit, then realign to mid-bit.
          if (r_cnt == CW'(BAUD_DIV / 2 - 1)) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= r_sync2 ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == CW'(BAUD_DIV - 1)) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= STOP;
            else               r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == CW'(BAUD_DIV - 1)) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A good stop bit delivers the byte; a low stop bit discards it.
  assign w_deliver = (r_state == STOP) && (r_cnt == CW'(BAUD_DIV - 1)) && r_sync2;
  assign w_pop     = i_pop && r_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (i_clr_ovr) r_ovr <= 1'b0;
      if (w_deliver) begin
        // A pop in the same cycle frees the register for the new byte.
        if (!r_valid || w_pop) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_ovr;

endmodule

// File: rtl/cpu_data_responder.sv
// Responder for the CPU data-memory port. Decodes the MEM-stage address onto
// the data RAM, the UART and the cycle counter; read data is combinational
// so every access completes in one cycle.
//   clk, reset  : clock, asynchronous active-high reset
//   mem_addr    : byte address (bits [1:0] ignored)
//   mem_we      : write strobe
//   mem_wdata   : write data
//   mem_rd      : read strobe, gates read side effects only
//   mem_rdata   : combinational read data
//   uart_rxd    : serial input
//   uart_txd    : serial output, idles high
module cpu_data_responder
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = 1024,
  parameter logic [31:0] RAM_BASE  = mem_map_pkg::RAM_BASE,
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned TXF_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic        mem_we,
  input  logic [31:0] mem_wdata,
  input  logic        mem_rd,
  output logic [31:0] mem_rdata,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam int unsigned BAUD_DIV = ((CLK_HZ / BAUD) < 4) ? 4 : (CLK_HZ / BAUD);
  localparam int unsigned AW = $clog2(RAM_DEPTH);
  localparam int unsigned FW = $clog2(TXF_DEPTH);
  localparam int unsigned CW = $clog2(BAUD_DIV);

  // ---------------- decode ----------------
  logic [29:0]   w_word_off;
  logic          w_ram_hit;
  logic [AW-1:0] w_ram_idx;
  logic          w_hit_data;
  logic          w_hit_stat;
  logic          w_hit_cyc;
  logic          w_unused_addr_bits;

  assign w_word_off = mem_addr[31:2] - RAM_BASE[31:2];
  assign w_ram_hit  = (mem_addr[31:2] >= RAM_BASE[31:2]) && (w_word_off[29:AW] == '0);
  assign w_ram_idx  = w_word_off[AW-1:0];
  assign w_hit_data = word_match(mem_addr, UART_DATA_ADDR);
  assign w_hit_stat = word_match(mem_addr, UART_STAT_ADDR);
  assign w_hit_cyc  = word_match(mem_addr, CYCLE_ADDR);
  assign w_unused_addr_bits = ^mem_addr[1:0];

  // ---------------- data RAM (not reset) ----------------
  logic [31:0] r_ram [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we && w_ram_hit) r_ram[w_ram_idx] <= mem_wdata;
  end

  // ---------------- cycle counter ----------------
  logic [31:0] r_cycle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cycle <= '0;
    else       r_cycle <= r_cycle + 32'd1;
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    r_txf_mem [TXF_DEPTH];
  logic [FW-1:0] r_txf_wp;
  logic [FW-1:0] r_txf_rp;
  logic [FW:0]   r_txf_cnt;
  logic          w_txf_full;
  logic          w_txf_empty;
  logic          w_tx_push;
  logic          w_tx_pop;

  uart_state_t   r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          r_txd;

  assign w_txf_full  = (r_txf_cnt == (FW + 1)'(TXF_DEPTH));
  assign w_txf_empty = (r_txf_cnt == '0);
  assign w_tx_pop    = (r_tx_state == IDLE) && !w_txf_empty;
  // A pop in the same cycle frees a slot, so a push to a full FIFO is kept.
  assign w_tx_push   = mem_we && w_hit_data && (!w_txf_full || w_tx_pop);

  always_ff @(posedge clk) begin
    if (w_tx_push) r_txf_mem[r_txf_wp] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txf_wp  <= '0;
      r_txf_rp  <= '0;
      r_txf_cnt <= '0;
    end else begin
      if (w_tx_push) r_txf_wp <= r_txf_wp + 1'b1;
      if (w_tx_pop)  r_txf_rp <= r_txf_rp + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_txf_cnt <= r_txf_cnt + 1'b1;
        2'b01:   r_txf_cnt <= r_txf_cnt - 1'b1;
        default: r_txf_cnt <= r_txf_cnt;
      endcase
    end
  end

  // ---------------- TX serializer ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else begin
      case (r_tx_state)
        IDLE: begin
          if (w_tx_pop) begin
            r_tx_shift <= r_txf_mem[r_txf_rp];
            r_tx_cnt   <= '0;
            r_txd      <= 1'b0;
            r_tx_state <= START;
          end
        end
        START: begin
          if (r_tx_cnt == CW'(BAUD_DIV - 1)) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_state <= DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_tx_cnt == CW'(BAUD_DIV - 1)) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= STOP;
            end else begin
              r_tx_bit   <= r_tx_bit + 1'b1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_txd      <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_tx_cnt == CW'(BAUD_DIV - 1)) begin
            r_tx_cnt   <= '0;
            r_tx_state <= IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: r_tx_state <= IDLE;
      endcase
    end
  end

  assign uart_txd = r_txd;

  // ---------------- RX ----------------
  logic [7:0] w_rx_data;
  logic       w_rx_valid;
  logic       w_rx_ovr;
  logic       w_rx_pop;
  logic       w_clr_ovr;

  assign w_rx_pop  = mem_rd && w_hit_data;
  assign w_clr_ovr = mem_we && w_hit_stat;

  uart_rx_deser #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .i_rxd    (uart_rxd),
    .i_pop    (w_rx_pop),
    .i_clr_ovr(w_clr_ovr),
    .o_data   (w_rx_data),
    .o_valid  (w_rx_valid),
    .o_overrun(w_rx_ovr)
  );

  // ---------------- read mux ----------------
  logic [3:0] w_stat;

  always_comb begin
    w_stat              = '0;
    w_stat[STAT_TXNF]   = !w_txf_full;
    w_stat[STAT_RXV]    = w_rx_valid;
    w_stat[STAT_OVR]    = w_rx_ovr;
    w_stat[STAT_TXIDLE] = w_txf_empty && (r_tx_state == IDLE);
  end

  always_comb begin
    mem_rdata = '0;
    if (w_ram_hit)       mem_rdata = r_ram[w_ram_idx];
    else if (w_hit_data) mem_rdata = {24'b0, w_rx_data};
    else if (w_hit_stat) mem_rdata = {28'b0, w_stat};
    else if (w_hit_cyc)  mem_rdata = r_cycle;
  end

endmodule

// File: tb/tb_cpu_data_responder.sv
// Self-checking bench for cpu_data_responder with BAUD_DIV = 10.
module tb_cpu_data_responder;
  import mem_map_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        uart_rxd;
  logic        uart_txd;

  cpu_data_responder #(
    .RAM_DEPTH(1024),
    .RAM_BASE (32'h1001_0000),
    .CLK_HZ   (1_000_000),
    .BAUD     (100_000),
    .TXF_DEPTH(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rd   (mem_rd),
    .mem_rdata(mem_rdata),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] q_bus [$];
  logic [7:0]  q_tx  [$];
  logic        mon_en;
  logic [31:0] tb_cyc;

  // Reference cycle counter.
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cyc <= '0;
    else       tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic sb_check(input string nm, input logic [31:0] act);
    logic [31:0] e;
    if (q_bus.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %h want <no expected entry>", nm, act);
    end else begin
      e = q_bus.pop_front();
      check(nm, act, e);
    end
  endtask

  task automatic chk_rd(input string nm, input logic [31:0] a, input logic rd, input logic [31:0] e);
    @(negedge clk);
    mem_we   = 1'b0;
    mem_addr = a;
    mem_rd   = rd;
    q_bus.push_back(e);
    #1 sb_check(nm, mem_rdata);
    @(negedge clk);
    mem_rd   = 1'b0;
    mem_addr = '0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_we    = 1'b1;
    mem_rd    = 1'b0;
    mem_addr  = a;
    mem_wdata = d;
    @(negedge clk);
    mem_we   = 1'b0;
    mem_addr = '0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (10) @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (10) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (10) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // TX monitor: decodes frames on uart_txd and compares against q_tx.
  initial begin : tx_mon
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && uart_txd === 1'b0) begin
        repeat (4) @(negedge clk);
        check("tx_mon_start", {31'b0, uart_txd}, 32'h0);
        for (int unsigned i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (10) @(negedge clk);
        check("tx_mon_stop", {31'b0, uart_txd}, 32'h1);
        if (q_tx.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_unexpected: got byte %h want none", b);
        end else begin
          e = q_tx.pop_front();
          check("tx_mon_byte", {24'b0, b}, {24'b0, e});
        end
      end
    end
  end

  initial begin : watchdog
    #400_000;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [15];

  initial begin : main
    logic [9:0]  pat;
    logic [9:0]  smp;
    int unsigned k;

    reset = 1'b1; mem_addr = '0; mem_we = 1'b0; mem_wdata = '0; mem_rd = 1'b0;
    uart_rxd = 1'b1; mon_en = 1'b1;

    vt[0]  = '{1'b0, UART_STAT_ADDR, 32'h0,          1'b1, 32'h9};
    vt[1]  = '{1'b1, 32'h1001_0004,  32'hDEADBEEF,   1'b0, 32'h0};
    vt[2]  = '{1'b0, 32'h1001_0004,  32'h0,          1'b1, 32'hDEADBEEF};
    vt[3]  = '{1'b1, 32'h1001_0000,  32'h1,          1'b0, 32'h0};
    vt[4]  = '{1'b0, 32'h1001_0000,  32'h0,          1'b1, 32'h1};
    vt[5]  = '{1'b0, 32'h2000_0000,  32'h0,          1'b1, 32'h0};
    vt[6]  = '{1'b0, 32'h1001_0007,  32'h0,          1'b1, 32'hDEADBEEF};
    vt[7]  = '{1'b1, 32'h1001_0FFC,  32'hCAFEF00D,   1'b0, 32'h0};
    vt[8]  = '{1'b0, 32'h1001_0FFC,  32'h0,          1'b1, 32'hCAFEF00D};
    vt[9]  = '{1'b0, 32'h1001_1000,  32'h0,          1'b1, 32'h0};
    vt[10] = '{1'b1, 32'h1001_1000,  32'h12345678,   1'b1, 32'h0};
    vt[11] = '{1'b0, 32'h1000_FFFC,  32'h0,          1'b1, 32'h0};
    vt[12] = '{1'b1, 32'h1001_0004,  32'h0BADF00D,   1'b1, 32'hDEADBEEF};
    vt[13] = '{1'b0, 32'h1001_0004,  32'h0,          1'b1, 32'h0BADF00D};
    vt[14] = '{1'b0, 32'h1001_0000,  32'h0,          1'b1, 32'h1};

    // Reset state.
    #1 check("rst_txd", {31'b0, uart_txd}, 32'h1);
    mem_addr = UART_STAT_ADDR;
    #1 check("rst_stat", mem_rdata, 32'h9);
    mem_addr = CYCLE_ADDR;
    #1 check("rst_cycle", mem_rdata, 32'h0);
    mem_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Table-driven bus vectors.
    for (int unsigned i = 0; i < 15; i++) begin
      @(negedge clk);
      mem_we    = vt[i].we;
      mem_addr  = vt[i].addr;
      mem_wdata = vt[i].wdata;
      mem_rd    = 1'b0;
      if (vt[i].chk) q_bus.push_back(vt[i].exp);
      #1;
      if (vt[i].chk) sb_check($sformatf("vec%0d", i), mem_rdata);
    end
    @(negedge clk);
    mem_we = 1'b0; mem_addr = '0;

    // Cycle counter: consecutive reads, and writes ignored.
    @(negedge clk);
    mem_addr = CYCLE_ADDR;
    #1 check("cycle_a", mem_rdata, tb_cyc);
    @(negedge clk);
    #1 check("cycle_b", mem_rdata, tb_cyc);
    bus_wr(CYCLE_ADDR, 32'h0);
    @(negedge clk);
    mem_addr = CYCLE_ADDR;
    #1 check("cycle_wr_ignored", mem_rdata, tb_cyc);
    mem_addr = '0;

    // Single byte 0x55: exact waveform and status during/after frame.
    q_tx.push_back(8'h55);
    bus_wr(UART_DATA_ADDR, 32'h0000_0055);
    mem_addr = UART_STAT_ADDR;
    #1 check("tx55_stat_pending", mem_rdata, 32'h1);
    check("tx55_pre_txd", {31'b0, uart_txd}, 32'h1);
    pat = {1'b1, 8'h55, 1'b0};
    for (int unsigned bi = 0; bi < 10; bi++) begin
      for (int unsigned s = 0; s < 10; s++) begin
        @(negedge clk);
        #1 smp[s] = uart_txd;
        if (bi == 5 && s == 0) check("tx55_stat_busy", mem_rdata, 32'h1);
      end
      check($sformatf("tx55_bit%0d", bi), {22'b0, smp}, pat[bi] ? 32'h3FF : 32'h0);
    end
    repeat (3) @(negedge clk);
    #1 check("tx55_stat_done", mem_rdata, 32'h9);
    mem_addr = '0;

    // Nine back-to-back bytes fill the FIFO; a tenth is dropped.
    for (int unsigned i = 0; i < 9; i++) begin
      @(negedge clk);
      mem_we    = 1'b1;
      mem_addr  = UART_DATA_ADDR;
      mem_wdata = 32'h30 + i;
      q_tx.push_back(8'(8'h30 + i));
    end
    @(negedge clk);
    mem_we = 1'b0; mem_addr = UART_STAT_ADDR;
    #1 check("txf_full_stat", mem_rdata, 32'h0);
    @(negedge clk);
    mem_we = 1'b1; mem_addr = UART_DATA_ADDR; mem_wdata = 32'hEE;
    @(negedge clk);
    mem_we = 1'b0; mem_addr = UART_STAT_ADDR;
    #1 check("txf_full_after_drop", mem_rdata, 32'h0);
    mem_addr = '0;
    k = 0;
    while (k < 1500 && q_tx.size() != 0) begin
      @(negedge clk);
      k++;
    end
    check("tx_drain_remaining", q_tx.size(), 32'h0);
    repeat (250) @(negedge clk);
    chk_rd("tx_all_done_stat", UART_STAT_ADDR, 1'b0, 32'h9);

    // RX single frame, peek then pop.
    send_rx(8'hA3, 1'b1);
    chk_rd("rx_stat_valid", UART_STAT_ADDR, 1'b0, 32'hB);
    chk_rd("rx_peek",       UART_DATA_ADDR, 1'b0, 32'hA3);
    chk_rd("rx_stat_peek",  UART_STAT_ADDR, 1'b0, 32'hB);
    chk_rd("rx_pop",        UART_DATA_ADDR, 1'b1, 32'hA3);
    chk_rd("rx_stat_pop",   UART_STAT_ADDR, 1'b0, 32'h9);

    // Overrun: second byte dropped, first kept.
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    chk_rd("ovr_stat",      UART_STAT_ADDR, 1'b0, 32'hF);
    chk_rd("ovr_data",      UART_DATA_ADDR, 1'b0, 32'h11);
    bus_wr(UART_STAT_ADDR, 32'hFFFF_FFFF);
    chk_rd("ovr_cleared",   UART_STAT_ADDR, 1'b0, 32'hB);
    chk_rd("ovr_pop",       UART_DATA_ADDR, 1'b1, 32'h11);
    chk_rd("ovr_stat_pop",  UART_STAT_ADDR, 1'b0, 32'h9);

    // Short glitch and framing error produce no byte.
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk_rd("glitch_stat",   UART_STAT_ADDR, 1'b0, 32'h9);
    send_rx(8'h5A, 1'b0);
    repeat (20) @(negedge clk);
    chk_rd("framing_stat",  UART_STAT_ADDR, 1'b0, 32'h9);

    // Reset mid-frame on both TX and RX.
    mon_en = 1'b0;
    bus_wr(UART_DATA_ADDR, 32'h0);
    uart_rxd = 1'b0;
    repeat (35) @(negedge clk);
    check("midrst_txd_low", {31'b0, uart_txd}, 32'h0);
    mem_addr = UART_STAT_ADDR;
    #2 reset = 1'b1;
    #1 check("midrst_txd_high", {31'b0, uart_txd}, 32'h1);
    check("midrst_stat", mem_rdata, 32'h9);
    uart_rxd = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    #1 check("postrst_stat", mem_rdata, 32'h9);
    check("postrst_txd", {31'b0, uart_txd}, 32'h1);
    mem_addr = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
